// File: rtl/sync_fifo_unit.sv
// Single-clock FIFO with registered read data and a one-cycle read-valid strobe.
// Used as the UART TX/RX byte buffers; consumers see popped data one edge after read_en.
module sync_fifo_unit #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_write_en,
    input  logic [WIDTH-1:0] fifo_write_data,
    input  logic             fifo_read_en,
    output logic             fifo_full,
    output logic             fifo_empty,
    output logic             fifo_out_valid,
    output logic [WIDTH-1:0] fifo_output
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] COUNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;

    logic wr_accept;
    logic rd_accept;

    // Flags come only from the registered count, so no input reaches an output combinationally.
    assign fifo_full  = (count_q == COUNT_FULL);
    assign fifo_empty = (count_q == '0);

    // A full FIFO drops writes even when a read frees a slot in the same cycle.
    assign wr_accept = fifo_write_en && !fifo_full;
    assign rd_accept = fifo_read_en && !fifo_empty;

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;

        if (wr_accept) begin
            wptr_d = wptr_q + AW'(1);
        end

        if (rd_accept) begin
            rptr_d      = rptr_q + AW'(1);
            out_valid_d = 1'b1;
            out_data_d  = mem_q[rptr_q];
        end

        unique case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is deliberately left out of reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wptr_q] <= fifo_write_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign fifo_out_valid = out_valid_q;
    assign fifo_output    = out_data_q;

endmodule

// File: tb/tb_sync_fifo_unit.sv
// Bench for sync_fifo_unit: directed scenarios plus random traffic against a queue model.
module tb_sync_fifo_unit;

    localparam int DEPTH = 32;
    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             fifo_write_en;
    logic [WIDTH-1:0] fifo_write_data;
    logic             fifo_read_en;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_out_valid;
    logic [WIDTH-1:0] fifo_output;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] model_q [$];
    logic [WIDTH-1:0] last_out;

    sync_fifo_unit #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .fifo_write_en   (fifo_write_en),
        .fifo_write_data (fifo_write_data),
        .fifo_read_en    (fifo_read_en),
        .fifo_full       (fifo_full),
        .fifo_empty      (fifo_empty),
        .fifo_out_valid  (fifo_out_valid),
        .fifo_output     (fifo_output)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input logic exp_valid);
        check_eq({tag, ".valid"}, 32'(fifo_out_valid), 32'(exp_valid));
        check_eq({tag, ".data"},  32'(fifo_output),    32'(last_out));
        check_eq({tag, ".empty"}, 32'(fifo_empty),     32'(model_q.size() == 0));
        check_eq({tag, ".full"},  32'(fifo_full),      32'(model_q.size() == DEPTH));
    endtask

    // One clock of traffic: the model applies the accept rules, then the DUT is sampled after the edge.
    task automatic step(input string tag, input logic we, input logic [WIDTH-1:0] wd, input logic re);
        logic wr_ok;
        logic rd_ok;
        @(negedge clk);
        fifo_write_en   = we;
        fifo_write_data = wd;
        fifo_read_en    = re;
        wr_ok = we && (model_q.size() < DEPTH);
        rd_ok = re && (model_q.size() != 0);
        if (rd_ok) last_out = model_q.pop_front();
        if (wr_ok) model_q.push_back(wd);
        @(posedge clk);
        #1;
        check_outputs(tag, rd_ok);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst             = 1'b0;
        fifo_write_en   = 1'b0;
        fifo_write_data = '0;
        fifo_read_en    = 1'b0;
        last_out        = '0;

        // Reset held: enables toggle but nothing may move.
        #1;
        check_outputs("rst0", 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            fifo_write_en   = i[0];
            fifo_read_en    = ~i[0];
            fifo_write_data = 8'($urandom);
            @(posedge clk);
            #1;
            check_outputs("rst_hold", 1'b0);
        end
        @(negedge clk);
        fifo_write_en = 1'b0;
        fifo_read_en  = 1'b0;
        rst = 1'b1;

        // Single item round trip.
        step("single_wr", 1'b1, 8'hA5, 1'b0);
        step("single_rd", 1'b0, 8'h00, 1'b1);
        check_eq("single_val", 32'(fifo_output), 32'h0000_00A5);
        step("single_idle", 1'b0, 8'h00, 1'b0);

        // Fill, overflow, drain in order.
        for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 8'(i), 1'b0);
        check_eq("fill_full", 32'(fifo_full), 32'd1);
        step("overflow", 1'b1, 8'hFF, 1'b0);
        step("overflow_rdwr", 1'b1, 8'hEE, 1'b1);
        check_eq("overflow_rd0", 32'(fifo_output), 32'd0);
        for (int i = 1; i < DEPTH; i++) begin
            step("drain", 1'b0, 8'h00, 1'b1);
            check_eq("drain_order", 32'(fifo_output), 32'(i));
        end
        check_eq("drain_empty", 32'(fifo_empty), 32'd1);

        // Underflow: output keeps the last popped value.
        step("underflow", 1'b0, 8'h00, 1'b1);
        check_eq("underflow_hold", 32'(fifo_output), 32'h1F);
        step("underflow2", 1'b0, 8'h00, 1'b1);

        // Wrap with concurrency at a steady depth of five.
        for (int i = 0; i < 5; i++) step("pre5", 1'b1, 8'($urandom), 1'b0);
        for (int i = 0; i < 40; i++) begin
            step("wrap_rw", 1'b1, 8'($urandom), 1'b1);
            check_eq("wrap_depth", 32'(model_q.size()), 32'd5);
        end
        for (int i = 0; i < 5; i++) step("post5", 1'b0, 8'h00, 1'b1);

        // Read plus write on empty: only the write lands, no bypass.
        step("empty_rw", 1'b1, 8'h3C, 1'b1);
        check_eq("empty_rw_valid", 32'(fifo_out_valid), 32'd0);
        step("empty_rw_rd", 1'b0, 8'h00, 1'b1);
        check_eq("empty_rw_data", 32'(fifo_output), 32'h3C);

        // Random traffic, biased phases to visit both full and empty.
        for (int i = 0; i < 1500; i++) begin
            int wbias;
            wbias = ((i / 200) % 2 == 0) ? 75 : 25;
            step("rand", 1'($urandom_range(99) < wbias), 8'($urandom),
                 1'($urandom_range(99) >= wbias));
        end

        // Async reset mid-stream with ten entries and a fresh strobe visible.
        while (model_q.size() != 0) step("pre_rst_drain", 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 11; i++) step("pre_rst_fill", 1'b1, 8'(8'h40 + i), 1'b0);
        step("pre_rst_rd", 1'b0, 8'h00, 1'b1);
        check_eq("pre_rst_valid", 32'(fifo_out_valid), 32'd1);
        check_eq("pre_rst_count", 32'(model_q.size()), 32'd10);
        #2;
        rst = 1'b0;
        fifo_read_en = 1'b1;
        #1;
        model_q.delete();
        last_out = '0;
        check_outputs("async_rst", 1'b0);
        @(posedge clk);
        #1;
        check_outputs("rst_inflight", 1'b0);
        @(negedge clk);
        fifo_read_en = 1'b0;
        rst = 1'b1;
        step("post_rst_rd", 1'b0, 8'h00, 1'b1);
        step("post_rst_rd2", 1'b0, 8'h00, 1'b1);
        step("post_rst_wr", 1'b1, 8'h77, 1'b0);
        step("post_rst_rd3", 1'b0, 8'h00, 1'b1);
        check_eq("post_rst_data", 32'(fifo_output), 32'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
